// File: rtl/cpu_phase_sequencer.sv
// Steps one CPU instruction through FETCH/REGRD/MEM/WB and emits a strobe at the start of each phase.
// Define SEQ_BREAK_EN to add the PC breakpoint ports (bp_en, bp_addr, pc_value, bp_hit).
//
// state | meaning
// IDLE  | waiting for free-run enable or a step edge
// FETCH | PC update phase, pc_clk on its first cycle
// REGRD | register-file read phase, rf_rd on its first cycle
// MEM   | data-memory write phase, mem_wr on its first cycle
// WB    | write-back phase, rf_wr on its first cycle; retires the instruction
module cpu_phase_sequencer #(
    parameter int FETCH_CYC = 5,
    parameter int REGRD_CYC = 10,
    parameter int MEM_CYC   = 10,
    parameter int WB_CYC    = 10,
    parameter int ICNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run_mode,
    input  logic              step,
    input  logic              halt,
`ifdef SEQ_BREAK_EN
    input  logic              bp_en,
    input  logic [31:0]       bp_addr,
    input  logic [31:0]       pc_value,
    output logic              bp_hit,
`endif
    output logic              pc_clk,
    output logic              rf_rd,
    output logic              mem_wr,
    output logic              rf_wr,
    output logic              busy,
    output logic              halted,
    output logic [2:0]        phase,
    output logic [ICNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_REGRD = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4
    } state_t;

    localparam logic [5:0] FETCH_LAST = 6'(FETCH_CYC - 1);
    localparam logic [5:0] REGRD_LAST = 6'(REGRD_CYC - 1);
    localparam logic [5:0] MEM_LAST   = 6'(MEM_CYC - 1);
    localparam logic [5:0] WB_LAST    = 6'(WB_CYC - 1);

    state_t     state, state_nxt;
    logic [5:0] pcnt, pcnt_nxt, last_cnt;
    logic       step_q, step_edge, phase_end, wb_end, auto_ok, wb_stop;

    assign step_edge = step & ~step_q;

    always_comb begin
        case (state)
            S_FETCH: last_cnt = FETCH_LAST;
            S_REGRD: last_cnt = REGRD_LAST;
            S_MEM:   last_cnt = MEM_LAST;
            S_WB:    last_cnt = WB_LAST;
            default: last_cnt = 6'd0;
        endcase
    end

    assign phase_end = (state != S_IDLE) && (pcnt == last_cnt);
    assign wb_end    = (state == S_WB) && phase_end;

`ifdef SEQ_BREAK_EN
    logic bp_match;
    assign bp_match = bp_en && (pc_value == bp_addr);
    // A pending breakpoint suppresses auto-start; only a step edge resumes.
    assign auto_ok  = run_mode & ~halt & ~bp_hit;
    assign wb_stop  = bp_match;
`else
    assign auto_ok  = run_mode & ~halt;
    assign wb_stop  = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        pcnt_nxt  = pcnt + 6'd1;
        case (state)
            S_IDLE: begin
                pcnt_nxt = 6'd0;
                if (auto_ok || step_edge) state_nxt = S_FETCH;
            end
            S_FETCH: if (phase_end) begin state_nxt = S_REGRD; pcnt_nxt = 6'd0; end
            S_REGRD: if (phase_end) begin state_nxt = S_MEM;   pcnt_nxt = 6'd0; end
            S_MEM:   if (phase_end) begin state_nxt = S_WB;    pcnt_nxt = 6'd0; end
            S_WB: begin
                if (phase_end) begin
                    pcnt_nxt  = 6'd0;
                    state_nxt = (auto_ok && !wb_stop) ? S_FETCH : S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                pcnt_nxt  = 6'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pcnt      <= 6'd0;
            step_q    <= 1'b0;
            instr_cnt <= '0;
        end else begin
            state  <= state_nxt;
            pcnt   <= pcnt_nxt;
            step_q <= step;
            if (wb_end) instr_cnt <= instr_cnt + ICNT_W'(1);
        end
    end

`ifdef SEQ_BREAK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bp_hit <= 1'b0;
        end else if (wb_end && bp_match) begin
            bp_hit <= 1'b1;
        end else if (state == S_IDLE && state_nxt == S_FETCH) begin
            bp_hit <= 1'b0;
        end
    end
`endif

    assign pc_clk = (state == S_FETCH) && (pcnt == 6'd0);
    assign rf_rd  = (state == S_REGRD) && (pcnt == 6'd0);
    assign mem_wr = (state == S_MEM)   && (pcnt == 6'd0);
    assign rf_wr  = (state == S_WB)    && (pcnt == 6'd0);
    assign busy   = (state != S_IDLE);
    assign halted = (state == S_IDLE) && !auto_ok;
    assign phase  = state;

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Directed bench for cpu_phase_sequencer at default phase lengths (5/10/10/10, period 35).
// Define SEQ_BREAK_EN to also exercise the breakpoint stop.
module tb_cpu_phase_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, run_mode, step, halt;
    logic        pc_clk, rf_rd, mem_wr, rf_wr, busy, halted;
    logic [2:0]  phase;
    logic [15:0] instr_cnt;
`ifdef SEQ_BREAK_EN
    logic        bp_en, bp_hit;
    logic [31:0] bp_addr, pc_value;
    assign pc_value = {14'd0, instr_cnt, 2'b00};
`endif

    int checks   = 0;
    int failures = 0;

    // per-window strobe statistics filled in by watch()
    int n_pc, n_rd, n_mem, n_wr, n_busy;
    int f_pc, f_rd, f_mem, f_wr, l_pc;

    cpu_phase_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run_mode  (run_mode),
        .step      (step),
        .halt      (halt),
`ifdef SEQ_BREAK_EN
        .bp_en     (bp_en),
        .bp_addr   (bp_addr),
        .pc_value  (pc_value),
        .bp_hit    (bp_hit),
`endif
        .pc_clk    (pc_clk),
        .rf_rd     (rf_rd),
        .mem_wr    (mem_wr),
        .rf_wr     (rf_wr),
        .busy      (busy),
        .halted    (halted),
        .phase     (phase),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Observe n cycles starting at the current negedge; index 0 is the current cycle.
    task automatic watch(input int n);
        n_pc = 0; n_rd = 0; n_mem = 0; n_wr = 0; n_busy = 0;
        f_pc = -1; f_rd = -1; f_mem = -1; f_wr = -1; l_pc = -1;
        for (int i = 0; i < n; i++) begin
            if (pc_clk) begin if (n_pc == 0) f_pc = i; l_pc = i; n_pc++; end
            if (rf_rd)  begin if (n_rd == 0) f_rd = i; n_rd++; end
            if (mem_wr) begin if (n_mem == 0) f_mem = i; n_mem++; end
            if (rf_wr)  begin if (n_wr == 0) f_wr = i; n_wr++; end
            if (busy) n_busy++;
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0; run_mode = 1'b0; step = 1'b0; halt = 1'b0;
`ifdef SEQ_BREAK_EN
        bp_en = 1'b0; bp_addr = 32'h0;
`endif
        cyc(3);
        check("rst_phase",  32'(phase), 0);
        check("rst_busy",   32'(busy), 0);
        check("rst_pc_clk", 32'(pc_clk), 0);
        check("rst_icnt",   32'(instr_cnt), 0);
        check("rst_halted", 32'(halted), 1);
        rst_n = 1'b1;
        cyc(5);
        check("idle_phase", 32'(phase), 0);

        // single step: one full instruction
        step = 1'b1;
        cyc(1);
        check("t1_pc_clk", 32'(pc_clk), 1);
        check("t1_phase",  32'(phase), 1);
        watch(35);
        check("t1_n_pc",   32'(n_pc), 1);
        check("t1_f_rd",   32'(f_rd), 5);
        check("t1_f_mem",  32'(f_mem), 15);
        check("t1_f_wr",   32'(f_wr), 25);
        check("t1_busy",   32'(n_busy), 35);
        check("t1_phase_end", 32'(phase), 0);
        check("t1_icnt",   32'(instr_cnt), 1);
        check("t1_halted", 32'(halted), 1);
        step = 1'b0;
        cyc(2);

        // held step plus extra edges while busy: one instruction only
        step = 1'b1;
        cyc(1);
        check("t4_pc_clk", 32'(pc_clk), 1);
        cyc(1); step = 1'b0;
        cyc(1); step = 1'b1;
        watch(200);
        check("t4_n_pc",   32'(n_pc), 0);
        check("t4_n_wr",   32'(n_wr), 1);
        check("t4_f_wr",   32'(f_wr), 23);
        check("t4_icnt",   32'(instr_cnt), 2);
        check("t4_busy",   32'(busy), 0);
        step = 1'b0;
        cyc(2);

        // reset during MEM with pcnt=4
        step = 1'b1;
        cyc(1);
        cyc(19);
        check("t5_in_mem", 32'(phase), 3);
        rst_n = 1'b0;
        #1;
        check("t5_busy",   32'(busy), 0);
        check("t5_phase",  32'(phase), 0);
        check("t5_icnt",   32'(instr_cnt), 0);
        check("t5_strobes", 32'({pc_clk, rf_rd, mem_wr, rf_wr}), 0);
        step = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        watch(40);
        check("t5_no_wr",  32'(n_wr), 0);
        check("t5_no_pc",  32'(n_pc), 0);
        check("t5_icnt_after", 32'(instr_cnt), 0);

        // free run from reset release
        rst_n = 1'b0; run_mode = 1'b1;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        check("t2_pc_clk", 32'(pc_clk), 1);
        watch(105);
        check("t2_n_pc",   32'(n_pc), 3);
        check("t2_l_pc",   32'(l_pc), 70);
        check("t2_busy",   32'(n_busy), 105);
        check("t2_icnt",   32'(instr_cnt), 3);
        check("t2_next_pc", 32'(pc_clk), 1);

        // halt raised in REGRD: instruction completes, then idle
        cyc(7);
        check("t3_in_regrd", 32'(phase), 2);
        halt = 1'b1;
        watch(40);
        check("t3_n_pc",   32'(n_pc), 0);
        check("t3_n_wr",   32'(n_wr), 1);
        check("t3_f_wr",   32'(f_wr), 18);
        check("t3_phase",  32'(phase), 0);
        check("t3_halted", 32'(halted), 1);
        check("t3_icnt",   32'(instr_cnt), 4);
        step = 1'b1;
        cyc(1);
        check("t3_step_pc", 32'(pc_clk), 1);
        watch(60);
        check("t3_step_n_pc", 32'(n_pc), 1);
        check("t3_step_n_wr", 32'(n_wr), 1);
        check("t3_step_busy", 32'(n_busy), 35);
        check("t3_step_icnt", 32'(instr_cnt), 5);
        step = 1'b0; halt = 1'b0; run_mode = 1'b0;
        cyc(2);

`ifdef SEQ_BREAK_EN
        // breakpoint at pc 0x0C (fourth instruction) stops free run
        rst_n = 1'b0; run_mode = 1'b1; bp_en = 1'b1; bp_addr = 32'h0C;
        cyc(2);
        check("bp_rst", 32'(bp_hit), 0);
        rst_n = 1'b1;
        cyc(1);
        watch(180);
        check("bp_n_pc",  32'(n_pc), 4);
        check("bp_hit",   32'(bp_hit), 1);
        check("bp_phase", 32'(phase), 0);
        check("bp_icnt",  32'(instr_cnt), 4);
        check("bp_halted", 32'(halted), 1);
        run_mode = 1'b0;
        step = 1'b1;
        cyc(1);
        check("bp_step_pc",  32'(pc_clk), 1);
        check("bp_cleared",  32'(bp_hit), 0);
        watch(50);
        check("bp_step_n_pc", 32'(n_pc), 1);
        check("bp_step_icnt", 32'(instr_cnt), 5);
        step = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
